// File: rtl/rf_ctrl.sv
// Register-file instruction controller: decodes NOP/CLR/MOV/LDI bytes and sequences
// register-file reads and one-hot writes, with an idle timeout while waiting for an immediate.
module rf_ctrl #(
  parameter int IMM_TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] INSTR,
  input  logic       INSTR_VALID,
  output logic       INSTR_READY,
  input  logic [7:0] RF_OUT,
  output logic [2:0] SEL,
  output logic [1:0] ADDR,
  output logic [7:0] DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] IMM   = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] LATCH = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] ABORT = 3'd5;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  localparam logic [8:0] TIMEOUT = 9'(IMM_TIMEOUT);

  logic [2:0] state;
  logic [7:0] cnt;
  logic [7:0] data_r;
  logic [1:0] dst_r;
  logic [1:0] src_r;
  logic       xfer;
  logic [8:0] cnt_inc;

  assign xfer    = INSTR_VALID && INSTR_READY;
  assign cnt_inc = {1'b0, cnt} + 9'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      data_r <= 8'd0;
      dst_r  <= 2'd0;
      src_r  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer && INSTR[7:6] != OP_NOP) begin
            dst_r <= INSTR[5:4];
            src_r <= INSTR[3:2];
          end
          if (xfer) begin
            case (INSTR[7:6])
              OP_CLR: begin
                data_r <= 8'd0;
                state  <= WRITE;
              end
              OP_MOV: state <= READ;
              OP_LDI: begin
                cnt   <= 8'd0;
                state <= IMM;
              end
              default: state <= IDLE;
            endcase
          end
        end
        // An immediate arriving on the same edge the counter expires still wins.
        IMM: begin
          if (xfer) begin
            data_r <= INSTR;
            state  <= WRITE;
          end else begin
            cnt <= cnt_inc[7:0];
            if (cnt_inc == TIMEOUT) state <= ABORT;
          end
        end
        READ:  state <= LATCH;
        LATCH: begin
          data_r <= RF_OUT;
          state  <= WRITE;
        end
        WRITE:   state <= IDLE;
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore outputs; READY is also gated by reset so it drops the moment RST_N falls.
  always_comb begin
    INSTR_READY = RST_N && (state == IDLE || state == IMM);
    BUSY        = (state != IDLE);
    SEL         = 3'b000;
    ADDR        = 2'b00;
    DATA        = 8'h00;
    DONE        = 1'b0;
    ERR         = 1'b0;
    case (state)
      READ: ADDR = src_r;
      WRITE: begin
        DONE = 1'b1;
        DATA = data_r;
        if (dst_r == 2'd3) ERR = 1'b1;
        else               SEL = 3'b001 << dst_r;
      end
      ABORT: ERR = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/rf_ctrl.md
RF_CTRL -- requirements
Module: rf_ctrl

Interface
REQ-001 Parameter: IMM_TIMEOUT, default 16, max idle cycles in IMM before abort (legal range 1..255; 8-bit counter).
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 INSTR  in  8  instruction or immediate byte.
REQ-005 INSTR_VALID  in  1  INSTR holds a valid byte.
REQ-006 INSTR_READY  out  1  block accepts a byte; a transfer occurs on an edge where VALID and READY are both 1.
REQ-007 RF_OUT  in  8  registered read data from the register file.
REQ-008 SEL  out  3  one-hot write select to the register file (R0=001, R1=010, R2=100).
REQ-009 ADDR  out  2  read address to the register file (3 = RZ).
REQ-010 DATA  out  8  write data to the register file.
REQ-011 BUSY  out  1  high whenever state is not IDLE.
REQ-012 DONE  out  1  one-cycle pulse on instruction completion.
REQ-013 ERR  out  1  one-cycle error pulse.

Function
REQ-014 Instruction fields SHALL be: INSTR[7:6] opcode (00 NOP, 01 CLR, 10 MOV, 11 LDI), INSTR[5:4] dst, INSTR[3:2] src; INSTR[1:0] ignored.
REQ-015 FSM states SHALL be IDLE, IMM, READ, LATCH, WRITE, ABORT; all outputs are Moore, decoded from registered state, dst/src and data registers only.
REQ-016 INSTR_READY SHALL be 1 exactly in IDLE and IMM with RST_N high.
REQ-017 IDLE, accepted NOP: remain IDLE; no SEL, DONE or ERR activity.
REQ-018 IDLE, accepted CLR: data register <= 0, next state WRITE.
REQ-019 IDLE, accepted MOV: next state READ; ADDR = src during READ, 00 in every other state.
REQ-020 READ SHALL go to LATCH unconditionally; at the edge ending LATCH the data register SHALL capture RF_OUT; then WRITE.
REQ-021 IDLE, accepted LDI: next state IMM, timeout counter cleared; accepted byte in IMM loads data register, next state WRITE.
REQ-022 IMM counter SHALL increment each cycle without a transfer; on reaching IMM_TIMEOUT next state ABORT; a transfer in the same cycle as the counter reaching IMM_TIMEOUT SHALL win (goes to WRITE).
REQ-023 WRITE SHALL last exactly one cycle: SEL = one-hot(dst), DATA = data register, DONE = 1; next state IDLE.
REQ-024 dst = 3 in WRITE: SEL = 000 (write suppressed), DONE = 1 and ERR = 1.
REQ-025 ABORT SHALL last one cycle with ERR = 1, SEL = 000, DONE = 0; next state IDLE.
REQ-026 SEL SHALL be 000 and DATA SHALL be 00 in every state except WRITE.
REQ-027 Latency from accepting edge k: CLR write in cycle k+1; MOV READ k+1, LATCH k+2, WRITE k+3; LDI write in the cycle after the immediate transfer.
REQ-028 Back-to-back: a new instruction is accepted only from IDLE, so throughput is at most one CLR per 2 cycles.

Reset
REQ-029 RST_N low SHALL immediately force state IDLE, counter 0, data/dst/src registers 0, SEL 000, ADDR 00, DATA 00, INSTR_READY 0, BUSY 0, DONE 0, ERR 0.
REQ-030 Reset asserted mid-instruction SHALL abort it with no SEL pulse; INSTR_READY = 1 in the first cycle after RST_N rises.

Verification
REQ-031 Reset release, INSTR=8'h50 accepted -> next cycle SEL=010, DATA=00, DONE=1; following cycle BUSY=0.
REQ-032 INSTR=8'hE0 then 8'hA5 three cycles later -> BUSY during wait, then SEL=100, DATA=A5, DONE=1 one cycle after second transfer.
REQ-033 INSTR=8'hA0 at edge k, RF_OUT=8'h3C in cycle k+2 -> ADDR=00 in k+1, SEL=100, DATA=3C, DONE=1 in k+3.
REQ-034 INSTR=8'hC0, VALID low for 16 cycles -> ABORT with ERR=1 one cycle, SEL never nonzero, then INSTR_READY=1.
REQ-035 INSTR=8'h70 (CLR dst=3) -> WRITE cycle with SEL=000, ERR=1, DONE=1.
REQ-036 RST_N pulsed low during LATCH of a MOV -> outputs reset asynchronously, no SEL pulse, INSTR_READY=1 after release.
